// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the synchronous FIFO read-side
// drain engine (fifo_rd_stream) and its skid buffer (fifo_rd_skid).
package fifo_pkg;

  // Default width of a FIFO word and of the stream data.
  localparam int unsigned DEF_DATA_WIDTH = 12;

  // The skid buffer is built for exactly two entries.
  localparam int unsigned SKID_DEPTH_REQ = 2;

  // Skid-buffer occupancy, legal range 0..2.
  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  // A pop is safe only when every word already owed to the buffer (stored
  // plus the one in flight) leaves room for one more, assuming no drain.
  function automatic logic room_for_pop(input occ_t occ, input logic inflight);
    logic [2:0] owed;
    owed = {1'b0, occ} + {2'b00, inflight};
    return (owed < 3'd2);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: two-entry skid buffer between the FIFO read port and the
// valid/ready stream. Captures into the tail, drains from the head, and
// shifts tail to head when the head is accepted. Head drives m_data_o.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cap_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  m_ready_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output occ_t                  occ_o
);

  occ_t                  occ_r;
  occ_t                  occ_nxt_s;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] head_nxt_s;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [DATA_WIDTH-1:0] tail_nxt_s;
  logic                  valid_r;
  logic                  drain_s;

  // Next occupancy and entry contents from capture and drain requests.
  always_comb begin
    occ_nxt_s  = occ_r;
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    drain_s    = m_ready_i && (occ_r != OCC_EMPTY);
    case (occ_r)
      OCC_EMPTY: begin
        if (cap_i) begin
          head_nxt_s = cap_data_i;
          occ_nxt_s  = OCC_ONE;
        end else begin
          occ_nxt_s  = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (cap_i && drain_s) begin
          head_nxt_s = cap_data_i;
          occ_nxt_s  = OCC_ONE;
        end else if (cap_i) begin
          tail_nxt_s = cap_data_i;
          occ_nxt_s  = OCC_FULL;
        end else if (drain_s) begin
          occ_nxt_s  = OCC_EMPTY;
        end else begin
          occ_nxt_s  = OCC_ONE;
        end
      end
      OCC_FULL: begin
        // The pop rule keeps a capture from landing here without a drain;
        // the capture+drain arm only keeps the shift well defined.
        if (cap_i && drain_s) begin
          head_nxt_s = tail_r;
          tail_nxt_s = cap_data_i;
          occ_nxt_s  = OCC_FULL;
        end else if (drain_s) begin
          head_nxt_s = tail_r;
          occ_nxt_s  = OCC_ONE;
        end else begin
          occ_nxt_s  = OCC_FULL;
        end
      end
      default: begin
        // Unreachable occupancy code: recover to empty rather than stream junk.
        occ_nxt_s = OCC_EMPTY;
      end
    endcase
  end

  // Buffer state registers; valid is registered alongside occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_r   <= OCC_EMPTY;
      head_r  <= {DATA_WIDTH{1'b0}};
      tail_r  <= {DATA_WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else begin
      occ_r   <= occ_nxt_s;
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      valid_r <= (occ_nxt_s != OCC_EMPTY);
    end
  end

  assign m_valid_o = valid_r;
  assign m_data_o  = head_r;
  assign occ_o     = occ_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain engine for the synchronous FIFO. Issues
// pops, absorbs the FIFO's one-cycle read latency and presents the words as
// a valid/ready stream through a two-entry skid buffer.
// Optional feature macro: FIFO_RD_STREAM_STATS_EN adds pop_count_o, a 16-bit
// wrapping count of accepted stream handshakes.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned SKID_DEPTH = SKID_DEPTH_REQ
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  input  logic                  fifo_underflow_i,
  output logic                  fifo_rd_en_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic                  err_o
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [15:0]           pop_count_o
`endif
);

  if (SKID_DEPTH != SKID_DEPTH_REQ) begin : g_bad_skid_depth
    $error("fifo_rd_stream: SKID_DEPTH must be 2");
  end

  occ_t occ_s;
  logic inflight_r;
  logic err_r;
  logic rd_en_s;
  logic cap_s;

  // Pop decision: only FIFO empty and registered state, never m_ready_i, so
  // room is reserved for the worst case where the consumer stalls. Reset
  // forces the pop request low.
  always_comb begin
    rd_en_s = 1'b0;
    cap_s   = 1'b0;
    if (rst_i) begin
      rd_en_s = 1'b0;
    end else begin
      rd_en_s = !fifo_empty_i && room_for_pop(occ_s, inflight_r);
    end
    if (inflight_r && !fifo_underflow_i) begin
      cap_s = 1'b1;
    end else begin
      cap_s = 1'b0;
    end
  end

  // A pop issued this cycle returns data next cycle; underflow is sticky.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
      err_r      <= err_r | fifo_underflow_i;
    end
  end

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cap_i      (cap_s),
    .cap_data_i (fifo_rdata_i),
    .m_ready_i  (m_ready_i),
    .m_valid_o  (m_valid_o),
    .m_data_o   (m_data_o),
    .occ_o      (occ_s)
  );

  assign fifo_rd_en_o = rd_en_s;
  assign err_o        = err_r;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0] pop_count_r;

  // Count accepted stream handshakes, wrapping naturally at 16 bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pop_count_r <= 16'd0;
    end else if (m_valid_o && m_ready_i) begin
      pop_count_r <= pop_count_r + 16'd1;
    end else begin
      pop_count_r <= pop_count_r;
    end
  end

  assign pop_count_o = pop_count_r;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench for fifo_rd_stream with a behavioural
// FIFO model (combinational empty, registered read data, forced underflow).
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_rst;
  logic        force_uf;
  logic        m_ready;
  logic [11:0] fifo_rdata;
  logic        fifo_uf;
  logic        fifo_empty;
  logic        rd_en;
  logic        m_valid;
  logic [11:0] m_data;
  logic        err;
  logic [15:0] pop_count;

  logic [11:0] mem [0:4095];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [11:0] exp_q [$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          hs_cnt = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  fifo_rd_stream dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .fifo_empty_i     (fifo_empty),
    .fifo_rdata_i     (fifo_rdata),
    .fifo_underflow_i (fifo_uf),
    .fifo_rd_en_o     (rd_en),
    .m_valid_o        (m_valid),
    .m_data_o         (m_data),
    .m_ready_i        (m_ready),
    .err_o            (err)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .pop_count_o      (pop_count)
`endif
  );

`ifndef FIFO_RD_STREAM_STATS_EN
  assign pop_count = 16'd0;
`endif

  // FIFO model: registered read data, underflow pulse driven by the bench.
  always @(posedge clk or posedge fifo_rst) begin
    if (fifo_rst) begin
      rd_ptr     <= wr_ptr;
      fifo_rdata <= 12'd0;
      fifo_uf    <= 1'b0;
    end else begin
      fifo_uf <= force_uf;
      if (rd_en && !fifo_empty) begin
        fifo_rdata <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1;
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push_word(input logic [11:0] w);
    mem[wr_ptr] = w;
    exp_q.push_back(w);
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  // Stream monitor: scoreboard compare, hold stability and occupancy bound.
  initial begin
    logic        pv;
    logic        pr;
    logic [11:0] pd;
    logic [11:0] want;
    pv = 1'b0;
    pr = 1'b0;
    pd = 12'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv     = 1'b0;
        hs_cnt = 0;
      end else begin
        chk_eq("occ_le_2", {31'd0, (dut.u_skid.occ_r <= 2'd2)}, 32'd1);
        chk_eq("cap_into_full",
               {31'd0, (dut.inflight_r && !fifo_uf && dut.u_skid.occ_r == 2'd2)}, 32'd0);
        if (pv && !pr) begin
          chk_eq("hold_valid", {31'd0, m_valid}, 32'd1);
          chk_eq("hold_data", {20'd0, m_data}, {20'd0, pd});
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk_eq("sb_extra_word", exp_q.size(), 32'd1);
          end else begin
            want = exp_q.pop_front();
            chk_eq("stream_data", {20'd0, m_data}, {20'd0, want});
            hs_cnt++;
          end
        end
        pv = m_valid;
        pr = m_ready;
        pd = m_data;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_pop;
    int t_val;
    int pops;
    int lat;

    rst      = 1'b1;
    fifo_rst = 1'b1;
    force_uf = 1'b0;
    m_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    fifo_rst = 1'b0;

    // Reset state with a preloaded FIFO: no pop while reset is high.
    for (int i = 1; i <= 4; i++) push_word(12'(i));
    m_ready = 1'b1;
    @(negedge clk);
    chk_eq("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk_eq("rst_valid", {31'd0, m_valid}, 32'd0);
    chk_eq("rst_data", {20'd0, m_data}, 32'd0);
    chk_eq("rst_err", {31'd0, err}, 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk_eq("rst_stats", {16'd0, pop_count}, 32'd0);
`endif

    // Streaming 0x001..0x004 with ready held high.
    tick();
    rst   = 1'b0;
    t_pop = -1;
    t_val = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rd_en && t_pop < 0) t_pop = c;
      if (m_valid && t_val < 0) t_val = c;
    end
    chk_eq("first_pop_cycle", t_pop, 32'd0);
    chk_eq("pop_to_valid_lat", t_val - t_pop, 32'd2);
    chk_eq("t1_words", hs_cnt, 32'd4);
    chk_eq("t1_valid_drop", {31'd0, m_valid}, 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk_eq("t1_stats", {16'd0, pop_count}, 32'd4);
`endif

    // Backpressure: eight words, consumer stalled.
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(12'h100 + 12'(i));
    pops = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rd_en) pops++;
    end
    chk_eq("bp_pops", pops, 32'd2);
    chk_eq("bp_valid", {31'd0, m_valid}, 32'd1);
    chk_eq("bp_head", {20'd0, m_data}, 32'h100);
    chk_eq("bp_rd_en_low", {31'd0, rd_en}, 32'd0);
    tick();
    m_ready = 1'b1;
    wait_drain(40);
    chk_eq("bp_drained", exp_q.size(), 32'd0);

    // Random ready over 1000 words.
    tick();
    for (int i = 0; i < 1000; i++) push_word(12'($urandom));
    for (int i = 0; i < 8000 && exp_q.size() != 0; i++) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
    end
    tick();
    m_ready = 1'b1;
    wait_drain(10);
    chk_eq("rand_drained", exp_q.size(), 32'd0);
    chk_eq("rand_err", {31'd0, err}, 32'd0);

    // FIFO runs empty mid-burst, then a refill.
    tick();
    for (int i = 0; i < 3; i++) push_word(12'h300 + 12'(i));
    wait_drain(30);
    repeat (3) @(negedge clk);
    chk_eq("empty_rd_en", {31'd0, rd_en}, 32'd0);
    chk_eq("empty_valid", {31'd0, m_valid}, 32'd0);
    tick();
    push_word(12'h7E7);
    @(negedge clk);
    chk_eq("refill_pop", {31'd0, rd_en}, 32'd1);
    lat = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (m_valid && lat < 0) lat = c;
    end
    chk_eq("refill_lat", lat, 32'd2);
    wait_drain(10);

    // Underflow pulse while a pop is in flight.
    tick();
    push_word(12'hABC);
    @(negedge clk);
    chk_eq("uf_pop", {31'd0, rd_en}, 32'd1);
    force_uf = 1'b1;
    @(posedge clk);
    #1;
    force_uf = 1'b0;
    exp_q.delete(0);
    repeat (3) @(negedge clk);
    chk_eq("uf_no_capture", {31'd0, m_valid}, 32'd0);
    chk_eq("uf_err", {31'd0, err}, 32'd1);
    tick();
    push_word(12'h5A5);
    wait_drain(20);
    chk_eq("uf_next_word", exp_q.size(), 32'd0);
    chk_eq("uf_err_sticky", {31'd0, err}, 32'd1);

    // Asynchronous reset mid-burst with a full buffer.
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(12'h200 + 12'(i));
    repeat (6) @(negedge clk);
    chk_eq("pre_rst_valid", {31'd0, m_valid}, 32'd1);
    chk_eq("pre_rst_rd_en", {31'd0, rd_en}, 32'd0);
    @(posedge clk);
    #3;
    rst      = 1'b1;
    fifo_rst = 1'b1;
    #1;
    chk_eq("arst_valid", {31'd0, m_valid}, 32'd0);
    chk_eq("arst_data", {20'd0, m_data}, 32'd0);
    chk_eq("arst_err", {31'd0, err}, 32'd0);
    chk_eq("arst_rd_en", {31'd0, rd_en}, 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk_eq("arst_stats", {16'd0, pop_count}, 32'd0);
`endif
    exp_q.delete();
    tick();
    tick();
    rst      = 1'b0;
    fifo_rst = 1'b0;
    m_ready  = 1'b1;
    push_word(12'h0F1);
    push_word(12'h0F2);
    wait_drain(20);
    chk_eq("post_rst_drained", exp_q.size(), 32'd0);
    chk_eq("post_rst_err", {31'd0, err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
